addroundkey_stage: RTL and testbench

ADDROUNDKEY_STAGE -- requirements
Module: addroundkey_stage

---
 rtl/addroundkey_stage.sv | 112 +++++++++++
 tb/tb_addroundkey_stage.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/addroundkey_stage.sv
// AES AddRoundKey pipeline stage: 11-slot round-key store, one output register.
// Optional ARK_KEY_VALID_EN flags beats that read a never-written key slot.
module addroundkey_stage (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         key_we_i,
  input  logic [3:0]   key_idx_i,
  input  logic [127:0] key_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [127:0] text_i,
  input  logic [3:0]   round_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [127:0] text_o,
  output logic         err_o
);

  localparam int NSLOT = 11;

  logic [127:0] slot_q [NSLOT];
  logic [127:0] slot_d [NSLOT];
  logic [127:0] text_q, text_d;
  logic         valid_q, valid_d;
  logic         err_q, err_d;
  logic [127:0] rkey;
  logic         rnd_ok;
  logic         key_ok;
  logic         accept;

`ifdef ARK_KEY_VALID_EN
  logic [NSLOT-1:0] wr_q, wr_d;
`endif

  assign ready_o = ~valid_q | ready_i;
  assign accept  = valid_i & ready_o;
  assign valid_o = valid_q;
  assign text_o  = text_q;
  assign err_o   = err_q;

  // Key lookup reads the registered slots, so a same-cycle write is unseen.
  always_comb begin
    rnd_ok = (round_i <= 4'd10);
    rkey   = '0;
    key_ok = 1'b1;
`ifdef ARK_KEY_VALID_EN
    key_ok = 1'b0;
`endif
    for (int i = 0; i < NSLOT; i++) begin
      if (round_i == 4'(i)) begin
        rkey = slot_q[i];
`ifdef ARK_KEY_VALID_EN
        key_ok = wr_q[i];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      slot_d[i] = slot_q[i];
      if (key_we_i && key_idx_i == 4'(i))
        slot_d[i] = key_i;
    end
  end

`ifdef ARK_KEY_VALID_EN
  always_comb begin
    wr_d = wr_q;
    for (int i = 0; i < NSLOT; i++)
      if (key_we_i && key_idx_i == 4'(i))
        wr_d[i] = 1'b1;
  end
`endif

  always_comb begin
    valid_d = valid_q;
    text_d  = text_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      text_d  = text_i ^ rkey;
      err_d   = ~rnd_ok | ~key_ok;
    end else if (ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      text_q  <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < NSLOT; i++)
        slot_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      text_q  <= text_d;
      err_q   <= err_d;
      for (int i = 0; i < NSLOT; i++)
        slot_q[i] <= slot_d[i];
    end
  end

`ifdef ARK_KEY_VALID_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_q <= '0;
    else       wr_q <= wr_d;
  end
`endif

endmodule

// File: tb/tb_addroundkey_stage.sv
// Scoreboard bench for addroundkey_stage: directed beats, stall, reset, key hazards.
// Define ARK_KEY_VALID_EN here too when the DUT is built with it.
module tb_addroundkey_stage;

`ifdef ARK_KEY_VALID_EN
  localparam logic UNW_ERR = 1'b1;
`else
  localparam logic UNW_ERR = 1'b0;
`endif

  logic         clk = 0;
  logic         rst_i;
  logic         key_we_i;
  logic [3:0]   key_idx_i;
  logic [127:0] key_i;
  logic         valid_i;
  logic         ready_o;
  logic [127:0] text_i;
  logic [3:0]   round_i;
  logic         valid_o;
  logic         ready_i;
  logic [127:0] text_o;
  logic         err_o;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  logic [128:0] sb [$];
  int pop_cyc [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  addroundkey_stage dut (
    .clk_i(clk), .rst_i(rst_i),
    .key_we_i(key_we_i), .key_idx_i(key_idx_i), .key_i(key_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .text_i(text_i), .round_i(round_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .text_o(text_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  // Monitor: every beat handed downstream is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", text_o, 128'hx);
      end else begin
        logic [128:0] e;
        e = sb.pop_front();
        chk("text_o", text_o, e[127:0]);
        chk("err_o", {127'b0, err_o}, {127'b0, e[128]});
        pop_cyc.push_back(cyc);
      end
    end
  end

  task automatic write_key(input logic [3:0] idx, input logic [127:0] k);
    key_we_i = 1; key_idx_i = idx; key_i = k;
    @(posedge clk); #1;
    key_we_i = 0;
  endtask

  task automatic send(input logic [127:0] t, input logic [3:0] r,
                      input logic [127:0] et, input logic ee);
    int n = 0;
    valid_i = 1; text_i = t; round_i = r;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!ready_o) chk("accept_timeout", {127'b0, ready_o}, 128'h1);
    sb.push_back({ee, et});
    @(posedge clk); #1;
    valid_i = 0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 128'(sb.size()), 128'h0);
  endtask

  initial begin
    logic [127:0] hold;
    rst_i = 1; key_we_i = 0; key_idx_i = 0; key_i = 0;
    valid_i = 0; text_i = 0; round_i = 0; ready_i = 1;
    #12;
    chk("rst_valid", {127'b0, valid_o}, 128'h0);
    chk("rst_err", {127'b0, err_o}, 128'h0);
    chk("rst_text", text_o, 128'h0);
    @(posedge clk); #1;
    rst_i = 0;
    chk("rst_ready", {127'b0, ready_o}, 128'h1);

    // Basic vector
    write_key(4'd0, 128'h000102030405060708090a0b0c0d0e0f);
    send(128'h00112233445566778899aabbccddeeff, 4'd0,
         128'h00102030405060708090a0b0c0d0e0f0, 1'b0);
    wait_drain();

    // Back-to-back over all rounds
    for (int i = 0; i <= 10; i++)
      write_key(4'(i), {16{8'(i)}});
    write_key(4'd11, {16{8'hee}});
    pop_cyc.delete();
    for (int i = 0; i <= 10; i++)
      send(128'h0, 4'(i), {16{8'(i)}}, 1'b0);
    wait_drain();
    chk("b2b_count", 128'(pop_cyc.size()), 128'd11);
    if (pop_cyc.size() == 11)
      chk("b2b_nobubble", 128'(pop_cyc[10] - pop_cyc[0]), 128'd10);
    repeat (2) @(negedge clk);
    chk("drop_valid", {127'b0, valid_o}, 128'h0);

    // Stall with a pending second beat
    @(posedge clk); #1;
    ready_i = 0;
    send(128'h1111, 4'd2, 128'h1111 ^ {16{8'h02}}, 1'b0);
    hold = text_o;
    valid_i = 1; text_i = 128'h2222; round_i = 4'd4;
    sb.push_back({1'b0, 128'h2222 ^ {16{8'h04}}});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", {127'b0, ready_o}, 128'h0);
      chk("stall_text", text_o, hold);
      chk("stall_valid", {127'b0, valid_o}, 128'h1);
    end
    @(posedge clk); #1;
    ready_i = 1;
    @(posedge clk); #1;
    valid_i = 0;
    wait_drain();
    repeat (2) @(negedge clk);
    chk("drain_valid", {127'b0, valid_o}, 128'h0);

    // Asynchronous reset while a beat is held
    @(posedge clk); #1;
    ready_i = 0;
    send(128'h3333, 4'd1, 128'h3333 ^ {16{8'h01}}, 1'b0);
    #2 rst_i = 1;
    #1;
    chk("arst_valid", {127'b0, valid_o}, 128'h0);
    chk("arst_text", text_o, 128'h0);
    chk("arst_err", {127'b0, err_o}, 128'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_i = 0;
    chk("post_rst_ready", {127'b0, ready_o}, 128'h1);
    ready_i = 1;
    send(128'h0123456789abcdeffedcba9876543210, 4'd0,
         128'h0123456789abcdeffedcba9876543210, UNW_ERR);

    // Same-cycle write and accept on slot 5
    key_we_i = 1; key_idx_i = 4'd5; key_i = {16{8'hff}};
    valid_i = 1; text_i = 128'h0; round_i = 4'd5;
    sb.push_back({UNW_ERR, 128'h0});
    @(negedge clk);
    chk("same_ready", {127'b0, ready_o}, 128'h1);
    @(posedge clk); #1;
    key_we_i = 0; valid_i = 0;
    send(128'h0, 4'd5, {16{8'hff}}, 1'b0);

    // Unwritten slot and out-of-range round
    send(128'hdeadbeef, 4'd3, 128'hdeadbeef, UNW_ERR);
    send({16{8'ha5}}, 4'd12, {16{8'ha5}}, 1'b1);
    send(128'h5a5a, 4'd5, 128'h5a5a ^ {16{8'hff}}, 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
